// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel timing from an incoming active-low
// hsync/vsync pair, rebuilds h/v counters, checks line and frame geometry
// and reports lock status plus active-area x/y coordinates.
// Optional saturating error counter on err_count when VGA_DEC_ERRCNT_EN
// is defined; without it the port and counter are absent.
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
`ifdef VGA_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_A0   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_A1   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_A0   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_A1   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  // hs_s1/vs_s1 are the first input registers, hs_s2/vs_s2 the delayed copies
  logic       hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vs_pend_q, vs_pend_d;
  state_t     state_q, state_d;
  logic [7:0] good_q, good_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q, locked_d;
  logic       sync_err_q, sync_err_d;
  logic       h_edge, v_edge, frame_bnd, chk_en, geo_err, in_act;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
`endif

  // Edge detection, counters, geometry checks, FSM next state and outputs
  always_comb begin
    h_edge    = hs_s2_q & ~hs_s1_q;
    v_edge    = vs_s2_q & ~vs_s1_q;
    // a pending or coincident vsync fall turns this hsync into the frame boundary
    frame_bnd = h_edge & (vs_pend_q | v_edge);

    if (h_edge)      vs_pend_d = 1'b0;
    else if (v_edge) vs_pend_d = 1'b1;
    else             vs_pend_d = vs_pend_q;

    if (h_edge)                  h_cnt_d = '0;
    else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 10'd1;
    else                         h_cnt_d = h_cnt_q;

    if (frame_bnd)                         v_cnt_d = '0;
    else if (h_edge && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;
    else                                   v_cnt_d = v_cnt_q;

    // geometry is only policed once a frame boundary has been seen
    chk_en  = (state_q != SEARCH);
    geo_err = chk_en & ((h_edge & (h_cnt_q != H_LAST)) |
                        (~h_edge & (h_cnt_q == H_LAST)) |
                        (frame_bnd & (v_cnt_q != V_LAST)) |
                        (h_edge & ~frame_bnd & (v_cnt_q == V_LAST)));

    state_d = state_q;
    good_d  = good_q;
    if (geo_err) begin
      state_d = SEARCH;
      good_d  = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (frame_bnd) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end
        TRACK: begin
          if (frame_bnd) begin
            good_d = good_q + 8'd1;
            if (good_d == LOCK_N) state_d = LOCKED;
          end
        end
        LOCKED:  state_d = LOCKED;
        default: state_d = SEARCH;
      endcase
    end

    // outputs are computed from the next counter values so they line up
    // with the counters once registered
    in_act = (state_d == LOCKED) &&
             (h_cnt_d >= H_A0) && (h_cnt_d < H_A1) &&
             (v_cnt_d >= V_A0) && (v_cnt_d < V_A1);
    active_d      = in_act;
    x_d           = in_act ? (h_cnt_d - H_A0) : '0;
    y_d           = in_act ? (v_cnt_d - V_A0) : '0;
    line_start_d  = h_edge;
    frame_start_d = frame_bnd;
    locked_d      = (state_d == LOCKED);
    sync_err_d    = geo_err;

`ifdef VGA_DEC_ERRCNT_EN
    if (geo_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    else                               err_cnt_d = err_cnt_q;
`endif
  end

  // Input sync registers, timing counters and pixel outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_s1_q       <= 1'b1;
      hs_s2_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vs_pend_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      hs_s1_q       <= hsync;
      hs_s2_q       <= hs_s1_q;
      vs_s1_q       <= vsync;
      vs_s2_q       <= vs_s1_q;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_pend_q     <= vs_pend_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Lock FSM with registered locked flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= locked_d;
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  // Saturating geometry error counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 16x10 geometry.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int HT = 16;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int HA = 10;
  localparam int VT = 10;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VA = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] x, y;
  logic       active, line_start, frame_start, locked, sync_err;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int chk = 0;
  int err = 0;
  int se_cnt, ls_cnt, fs_cnt, act_cnt;
  bit check_pix = 1'b0;
  bit watch_lock = 1'b0;
  int err_line = -1;
  int rst_line = -1;
  int rst_i = -1;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hsync(hsync),
    .vsync(vsync),
    .x(x),
    .y(y),
    .active(active),
    .line_start(line_start),
    .frame_start(frame_start),
    .locked(locked),
    .sync_err(sync_err)
`ifdef VGA_DEC_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    se_cnt = 0; ls_cnt = 0; fs_cnt = 0; act_cnt = 0;
  endtask

  // One video line; samples are taken 1ns after each rising edge, so with
  // hsync falling at pixel 0 the decoder shows h_cnt = i-1 at pixel i.
  task automatic run_line(input int len, input bit hs_on, input bit vs_low, input int l);
    bit exp_act;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      hsync = !(hs_on && i < HS);
      vsync = !vs_low;
      rst_n = !(l == rst_line && i == rst_i);
      @(posedge clk);
      #1;
      se_cnt += int'(sync_err);
      ls_cnt += int'(line_start);
      fs_cnt += int'(frame_start);
      act_cnt += int'(active);
      if (check_pix) begin
        exp_act = (i > HS + HB) && (i <= HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        check("active", active, exp_act);
        check("x", x, exp_act ? i - (HS + HB + 1) : 0);
        check("y", y, exp_act ? l - (VS + VB) : 0);
        check("line_start", line_start, i == 1);
        check("frame_start", frame_start, i == 1 && l == 0);
        check("sync_err_clean", sync_err, 0);
        check("locked", locked, !(watch_lock && l == 0 && i == 0));
      end
      if (l == err_line && i <= 1) begin
        check("err_pulse", sync_err, i == 1);
        check("err_unlock", locked, i == 0);
        if (l == 0) check("err_frame_start", frame_start, i == 1);
      end
      if (l == rst_line && i == rst_i - 1) begin
        check("pre_rst_locked", locked, 1);
        check("pre_rst_active", active, 1);
        check("pre_rst_x", x, rst_i - 1 - (HS + HB + 1));
      end
      if (l == rst_line && i == rst_i) begin
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_active", active, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_sync_err", sync_err, 0);
`ifdef VGA_DEC_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
      end
    end
  endtask

  task automatic run_frame(input int nlines, input int short_l, input int miss_l);
    for (int l = 0; l < nlines; l++)
      run_line((l == short_l) ? HT - 1 : HT, l != miss_l, l < VS, l);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    check("reset_active", active, 0);
    check("reset_line_start", line_start, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_locked", locked, 0);
    check("reset_sync_err", sync_err, 0);
`ifdef VGA_DEC_ERRCNT_EN
    check("reset_err_count", err_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // acquire lock on an ideal stream
    clr();
    run_frame(VT, -1, -1);
    run_frame(VT, -1, -1);
    check("lock_not_yet", locked, 0);
    check("track_no_err", se_cnt, 0);
    clr();
    check_pix = 1'b1; watch_lock = 1'b1;
    run_frame(VT, -1, -1);
    watch_lock = 1'b0;
    check("active_per_frame", act_cnt, HA * VA);
    check("line_starts_per_frame", ls_cnt, VT);
    check("frame_starts_per_frame", fs_cnt, 1);
    clr();
    run_frame(VT, -1, -1);
    check_pix = 1'b0;
    check("active_per_frame2", act_cnt, HA * VA);
    check("locked_no_err", se_cnt, 0);

    // short line while locked
    clr(); err_line = 5;
    run_frame(VT, 4, -1);
    err_line = -1;
    check("short_line_err_cnt", se_cnt, 1);
    check("short_line_unlocked", locked, 0);
    clr();
    run_frame(VT, -1, -1);
    run_frame(VT, -1, -1);
    check("short_line_relock_pending", locked, 0);
    check_pix = 1'b1; watch_lock = 1'b1;
    run_frame(VT, -1, -1);
    check_pix = 1'b0; watch_lock = 1'b0;
    check("short_line_recover_clean", se_cnt, 0);

    // suppressed hsync while locked
    clr(); err_line = 4;
    run_frame(VT, -1, 4);
    err_line = -1;
    check("miss_hsync_err_cnt", se_cnt, 1);
    clr();
    run_frame(VT, -1, -1);
    check("miss_hsync_searching", locked, 0);
    run_frame(VT, -1, -1);
    check_pix = 1'b1; watch_lock = 1'b1;
    run_frame(VT, -1, -1);
    check_pix = 1'b0; watch_lock = 1'b0;
    check("miss_hsync_recover_clean", se_cnt, 0);

    // one frame one line short while locked
    clr();
    run_frame(VT - 1, -1, -1);
    check("short_frame_no_early_err", se_cnt, 0);
    clr(); err_line = 0;
    run_frame(VT, -1, -1);
    err_line = -1;
    check("short_frame_err_cnt", se_cnt, 1);
    check("short_frame_fs_cnt", fs_cnt, 1);
    clr();
    run_frame(VT, -1, -1);
    run_frame(VT, -1, -1);
    check_pix = 1'b1; watch_lock = 1'b1;
    run_frame(VT, -1, -1);
    check_pix = 1'b0; watch_lock = 1'b0;
    check("short_frame_recover_clean", se_cnt, 0);

    // reset mid-frame while locked
`ifdef VGA_DEC_ERRCNT_EN
    check("err_count_before_rst", err_count, 3);
`endif
    clr(); rst_line = 5; rst_i = 9;
    run_frame(VT, -1, -1);
    rst_line = -1; rst_i = -1;
    run_frame(VT, -1, -1);
    check("post_rst_tracking", locked, 0);
    run_frame(VT, -1, -1);
    check_pix = 1'b1; watch_lock = 1'b1;
    run_frame(VT, -1, -1);
    check_pix = 1'b0; watch_lock = 1'b0;
    check("post_rst_no_err", se_cnt, 0);

    // 300 short lines, each seen in TRACK/LOCKED
    clr();
    for (int k = 0; k < 300; k++) begin
      run_line(HT - 1, 1'b1, 1'b1, 100);
      run_line(HT, 1'b1, 1'b0, 100);
`ifdef VGA_DEC_ERRCNT_EN
      if (k == 253) check("err_count_254", err_count, 254);
      if (k == 254) check("err_count_255", err_count, 255);
`endif
    end
    check("burst_sync_err_pulses", se_cnt, 300);
    check("burst_unlocked", locked, 0);
`ifdef VGA_DEC_ERRCNT_EN
    check("err_count_saturated", err_count, 255);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("final_rst_locked", locked, 0);
`ifdef VGA_DEC_ERRCNT_EN
    check("final_rst_err_count", err_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers pixel timing from an incoming 640x480 VGA hsync/vsync pair on the pixel clock. It rebuilds the horizontal and vertical counters, checks each line and frame against the nominal 800x525 geometry, and reports lock status. It is the receive-side counterpart of the display timing generator and is used for loopback self-test and for downstream pixel capture logic that needs active-area x/y coordinates.

## Interface
Parameters:
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, active lines
- LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- x  out  10  active-area column 0..H_ACTIVE-1; 0 outside active
- y  out  10  active-area row 0..V_ACTIVE-1; 0 outside active
- active  out  1  pixel valid; only while locked
- line_start  out  1  one-cycle pulse when h_cnt loads 0
- frame_start  out  1  one-cycle pulse when v_cnt loads 0
- locked  out  1  lock achieved
- sync_err  out  1  one-cycle pulse on any geometry violation
- err_count  out  8  saturating error count; present only with VGA_DEC_ERRCNT_EN

## Operation
- hsync and vsync are registered into hs_r/vs_r and then delayed into hs_q/vs_q. All four reset to 1.
- h_edge = hs_q & ~hs_r. v_edge = vs_q & ~vs_r.
- h_cnt (10b): loads 0 on h_edge; otherwise increments, saturating at 1023.
- v_edge sets vs_pend. The next h_edge, including one in the same cycle, consumes vs_pend and is a frame boundary.
- v_cnt (10b): loads 0 on a frame-boundary h_edge; increments on other h_edges, saturating at 1023.
- Active region: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
- In the active region x = h_cnt-144 and y = v_cnt-35.
- FSM states:
  - SEARCH: no checks. First frame boundary goes to TRACK with good=0.
  - TRACK: each clean frame boundary increments good. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1.
- Errors are checked only in TRACK and LOCKED:
  - h_edge with h_cnt != H_TOTAL-1 (short line).
  - h_cnt == H_TOTAL-1 with no h_edge that cycle (missing hsync).
  - Frame boundary with v_cnt != V_TOTAL-1.
  - Non-boundary h_edge with v_cnt == V_TOTAL-1 (missing vsync).
- Any error: sync_err pulses, state goes to SEARCH, locked and active drop, good=0. Counters keep running.

## Timing
- All outputs are registered.
- Reset values: x=0, y=0, active=0, line_start=0, frame_start=0, locked=0, sync_err=0, err_count=0, state SEARCH, vs_pend=0.
- Latency: the first clk edge sampling hsync low is E. h_cnt reads 0 and line_start=1 after edge E+1.
- x and y are valid in the same cycle as active.
- locked, sync_err and active update at the same edge as the causing event.
- Reset mid-frame: on the first edge with rst_n=0, every register takes its reset value. Lock is re-acquired from SEARCH.
- Simultaneous v_edge and h_edge: that hsync is the frame boundary.

## Configuration
- VGA_DEC_ERRCNT_EN defined:
  - err_count port exists.
  - It increments on every sync_err pulse and saturates at 255.
  - It clears only on reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Ideal 800x525 stream with hsync low 96 clocks and vsync low 2 lines, applied after reset:
  - locked rises at the third frame boundary.
  - Then every line gives 640 active cycles with x 0..639, and every frame gives 480 active lines with y 0..479.
  - line_start occurs once per 800 clocks, and sync_err never fires.
- While locked, one line of 799 clocks:
  - sync_err pulses once; locked and active go to 0 at the same edge.
  - locked returns at the third subsequent frame boundary.
- While locked, one hsync pulse suppressed:
  - sync_err fires in the cycle h_cnt reaches 799.
  - State goes to SEARCH.
- While locked, one frame of 524 lines:
  - sync_err fires at that frame boundary.
  - frame_start still pulses.
- rst_n low for one cycle mid-frame (h_cnt=300, v_cnt=200):
  - All outputs are 0 after that edge.
  - No sync_err fires before the next lock.
- With VGA_DEC_ERRCNT_EN, 300 injected short lines (in TRACK/LOCKED):
  - err_count reaches 255 and holds.
  - Reset returns it to 0.
